// File: rtl/soc_trace_event_pkg.sv
// Shared types and constants for the per-core trace event unit.
package soc_trace_event_pkg;

   typedef enum logic [1:0] {
      EVT_NONE   = 2'd0,
      EVT_EXIT   = 2'd1,
      EVT_REPORT = 2'd2,
      EVT_PUTC   = 2'd3
   } evt_type_t;

   localparam logic [6:0]  NOP_OPCODE = 7'h13;
   localparam logic [11:0] IMM_EXIT   = 12'd1;
   localparam logic [11:0] IMM_REPORT = 12'd2;
   localparam logic [11:0] IMM_PUTC   = 12'd4;

   typedef struct packed {
      evt_type_t   etype;
      logic [31:0] data;
      logic [31:0] pc;
      logic [31:0] stamp;
   } evt_t;

   // Simulation-control NOP: addi x0,x0,imm with imm in {1,2,4}
   function automatic evt_type_t decode_ctrl(input logic [31:0] insn);
      evt_type_t t;
      t = EVT_NONE;
      if (insn[6:0] == NOP_OPCODE && insn[19:7] == '0) begin
         case (insn[31:20])
            IMM_EXIT:   t = EVT_EXIT;
            IMM_REPORT: t = EVT_REPORT;
            IMM_PUTC:   t = EVT_PUTC;
            default:    t = EVT_NONE;
         endcase
      end
      return t;
   endfunction

endpackage

// File: rtl/soc_trace_event_unit_if.sv
// Retire-stream input and event-stream output bundle for the trace event unit.
interface soc_trace_event_unit_if;
   import soc_trace_event_pkg::*;

   logic        trace_valid;
   logic [31:0] trace_pc;
   logic [31:0] trace_insn;
   logic        trace_wben;
   logic [4:0]  trace_wbreg;
   logic [31:0] trace_wbdata;

   logic        evt_valid;
   logic        evt_ready;
   evt_type_t   evt_type;
   logic [31:0] evt_data;
   logic [31:0] evt_pc;
   logic [31:0] evt_time;
   logic [15:0] evt_id;

   modport master (
      output trace_valid, trace_pc, trace_insn, trace_wben, trace_wbreg, trace_wbdata,
      output evt_ready,
      input  evt_valid, evt_type, evt_data, evt_pc, evt_time, evt_id
   );

   modport slave (
      input  trace_valid, trace_pc, trace_insn, trace_wben, trace_wbreg, trace_wbdata,
      input  evt_ready,
      output evt_valid, evt_type, evt_data, evt_pc, evt_time, evt_id
   );
endinterface

// File: rtl/soc_trace_event_fifo.sv
// Synchronous event FIFO; pointers carry an extra wrap bit to tell full from empty.
module soc_trace_event_fifo
   import soc_trace_event_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  evt_t                     wdata,
   output evt_t                     rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);

   evt_t           mem [DEPTH];
   logic [AW:0]    wptr;
   logic [AW:0]    rptr;

   // Pointer advance; caller guarantees no push when full without a pop, no pop when empty
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + (AW+1)'(1);
         if (pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];
   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/soc_trace_event_unit.sv
// Per-core trace event unit: r3 shadow, cycle counter, control-NOP decode, event FIFO, run/drain/done FSM.
module soc_trace_event_unit
   import soc_trace_event_pkg::*;
#(
   parameter int unsigned ID         = 0,
   parameter int unsigned REG_IDX    = 3,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   soc_trace_event_unit_if.slave  bus,
   output logic [31:0]            r3,
   output logic                   overflow,
   output logic                   terminated
);
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        decode_en;
   logic [31:0] cycle_cnt;
   evt_type_t   dec_type;
   logic        push_req;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   evt_t        wdata;
   evt_t        rdata;
   logic [$clog2(FIFO_DEPTH):0] count;

   assign dec_type = bus.trace_valid ? decode_ctrl(bus.trace_insn) : EVT_NONE;
   assign push_req = decode_en && (dec_type != EVT_NONE);
   assign pop      = !empty && bus.evt_ready;
   // A full FIFO still accepts when the head leaves in the same cycle
   assign push     = push_req && (!full || pop);
   assign wdata    = '{etype: dec_type, data: r3, pc: bus.trace_pc, stamp: cycle_cnt};

   soc_trace_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Shadow of the control-argument register
   always_ff @(posedge clk) begin
      if (!rst_n)
         r3 <= '0;
      else if (REG_IDX != 0 && bus.trace_valid && bus.trace_wben
               && bus.trace_wbreg == REG_IDX[4:0])
         r3 <= bus.trace_wbdata;
   end

   // Free-running timestamp counter
   always_ff @(posedge clk) begin
      if (!rst_n) cycle_cnt <= '0;
      else        cycle_cnt <= cycle_cnt + 32'd1;
   end

   // Sticky drop indicator
   always_ff @(posedge clk) begin
      if (!rst_n)                       overflow <= 1'b0;
      else if (push_req && full && !pop) overflow <= 1'b1;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_RUN;
      else        state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (push_req && dec_type == EVT_EXIT) state_nxt = ST_DRAIN;
         ST_DRAIN: if (count == '0)                      state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_DONE;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // FSM outputs
   always_comb begin
      decode_en  = (state == ST_RUN);
      terminated = (state == ST_DONE);
   end

   assign bus.evt_valid = !empty;
   assign bus.evt_type  = rdata.etype;
   assign bus.evt_data  = rdata.data;
   assign bus.evt_pc    = rdata.pc;
   assign bus.evt_time  = rdata.stamp;
   assign bus.evt_id    = ID[15:0];

endmodule

// File: tb/tb_soc_trace_event_unit.sv
// Directed bench for soc_trace_event_unit with a queue-based reference model.
module tb_soc_trace_event_unit;
   import soc_trace_event_pkg::*;

   localparam int unsigned P_ID    = 5;
   localparam int unsigned P_DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic [31:0] r3;
   logic        ovf;
   logic        term;

   soc_trace_event_unit_if bus ();

   soc_trace_event_unit #(.ID(P_ID), .REG_IDX(3), .FIFO_DEPTH(P_DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .r3         (r3),
      .overflow   (ovf),
      .terminated (term)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
   endtask

   // Reference model: events as a queue, phase 0=run 1=drain 2=done
   typedef struct { int t; logic [31:0] d; logic [31:0] pc; logic [31:0] tm; } mev_t;
   mev_t        mq[$];
   logic [31:0] m_r3, m_cnt;
   bit          m_ovf;
   int          m_ph;

   function automatic int ev_of(input logic v, input logic [31:0] insn);
      logic [11:0] imm;
      imm = insn[31:20];
      if (!v || insn[6:0] != 7'h13 || insn[19:7] != 13'd0) return 0;
      if (imm == 12'd1) return 1;
      if (imm == 12'd2) return 2;
      if (imm == 12'd4) return 3;
      return 0;
   endfunction

   always @(posedge clk) begin
      int   sz, et;
      bit   do_pop, do_push;
      mev_t e;
      if (!rst_n) begin
         mq.delete();
         m_r3 = 0; m_cnt = 0; m_ovf = 0; m_ph = 0;
      end else begin
         sz      = mq.size();
         do_pop  = (sz > 0) && bus.evt_ready;
         et      = ev_of(bus.trace_valid, bus.trace_insn);
         do_push = 0;
         if (m_ph == 1 && sz == 0) m_ph = 2;
         else if (m_ph == 0 && et != 0) begin
            if (sz < P_DEPTH || do_pop) do_push = 1;
            else m_ovf = 1;
            if (et == 1) m_ph = 1;
         end
         e.t = et; e.d = m_r3; e.pc = bus.trace_pc; e.tm = m_cnt;
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(e);
         if (bus.trace_valid && bus.trace_wben && bus.trace_wbreg == 5'd3) m_r3 = bus.trace_wbdata;
         m_cnt = m_cnt + 1;
      end
   end

   // Compare every cycle against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("evt_valid", {31'd0, bus.evt_valid}, {31'd0, mq.size() > 0});
         chk("r3", r3, m_r3);
         chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
         chk("terminated", {31'd0, term}, {31'd0, m_ph == 2});
         if (mq.size() > 0) begin
            chk("evt_type", {30'd0, bus.evt_type}, 32'(mq[0].t));
            chk("evt_data", bus.evt_data, mq[0].d);
            chk("evt_pc", bus.evt_pc, mq[0].pc);
            chk("evt_time", bus.evt_time, mq[0].tm);
            chk("evt_id", {16'd0, bus.evt_id}, 32'(P_ID));
         end
      end
   end

   function automatic logic [31:0] ctrl(input logic [11:0] imm, input logic [4:0] rd);
      return {imm, 5'd0, 3'd0, rd, 7'h13};
   endfunction

   task automatic idle();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] insn,
                         input logic wben, input logic [4:0] rd, input logic [31:0] wd);
      bus.trace_valid = 1'b1; bus.trace_pc = pc; bus.trace_insn = insn;
      bus.trace_wben = wben; bus.trace_wbreg = rd; bus.trace_wbdata = wd;
      @(posedge clk); #1;
      bus.trace_valid = 1'b0; bus.trace_wben = 1'b0;
   endtask

   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      @(negedge clk); #1;
      chk(name, act, exp);
   endtask

   logic [31:0] t_first;

   initial begin
      rst_n = 1'b0;
      bus.trace_valid = 0; bus.trace_pc = 0; bus.trace_insn = 0;
      bus.trace_wben = 0; bus.trace_wbreg = 0; bus.trace_wbdata = 0;
      bus.evt_ready = 0;

      do_reset();
      chk_en = 1;
      lit("reset_valid", {31'd0, bus.evt_valid}, 32'd0);
      chk("reset_r3", r3, 32'd0);

      // Test 1: x3=0x41 then PUTC
      retire(32'h0000_00F0, 32'h0000_0193, 1'b1, 5'd3, 32'h41);
      bus.evt_ready = 1'b1;
      retire(32'h0000_0100, ctrl(12'd4, 5'd0), 1'b0, 5'd0, 32'd0);
      @(negedge clk); #1;
      chk("t1_valid", {31'd0, bus.evt_valid}, 32'd1);
      chk("t1_type", {30'd0, bus.evt_type}, 32'd3);
      chk("t1_data", bus.evt_data, 32'h41);
      chk("t1_pc", bus.evt_pc, 32'h100);
      chk("t1_time", bus.evt_time, 32'd1);
      idle();
      bus.evt_ready = 1'b0;
      lit("t1_popped", {31'd0, bus.evt_valid}, 32'd0);

      // Test 5: non-control addi forms and a disabled writeback
      retire(32'h110, ctrl(12'd0, 5'd0), 1'b0, 5'd0, 32'd0);
      retire(32'h114, ctrl(12'd4, 5'd1), 1'b1, 5'd1, 32'd4);
      retire(32'h118, 32'h0000_0193, 1'b0, 5'd3, 32'hDEAD);
      retire(32'h11C, 32'h0000_0213, 1'b1, 5'd4, 32'hBEEF);
      lit("t5_no_evt", {31'd0, bus.evt_valid}, 32'd0);
      chk("t5_r3", r3, 32'h41);

      // Tests 3/2: fill, push+pop when full, then overflow
      for (int unsigned i = 0; i < 4; i++)
         retire(32'h200 + 32'(4*i), ctrl(12'd2, 5'd0), 1'b0, 5'd0, 32'd0);
      bus.evt_ready = 1'b1;
      retire(32'h210, ctrl(12'd2, 5'd0), 1'b0, 5'd0, 32'd0);
      bus.evt_ready = 1'b0;
      lit("t3_no_ovf", {31'd0, ovf}, 32'd0);
      chk("t3_head_pc", bus.evt_pc, 32'h204);
      retire(32'h214, ctrl(12'd2, 5'd0), 1'b0, 5'd0, 32'd0);
      lit("t2_ovf", {31'd0, ovf}, 32'd1);
      for (int unsigned i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("t2_order_pc", bus.evt_pc, 32'h204 + 32'(4*i));
         if (i == 0) t_first = bus.evt_time;
         if (i == 1) chk("t2_time_step", bus.evt_time - t_first, 32'd1);
         bus.evt_ready = 1'b1;
         idle();
         bus.evt_ready = 1'b0;
      end
      lit("t2_drained", {31'd0, bus.evt_valid}, 32'd0);

      // Test 6: reset with events queued and overflow set
      retire(32'h300, 32'h0000_0193, 1'b1, 5'd3, 32'd5);
      for (int unsigned i = 0; i < 5; i++)
         retire(32'h304 + 32'(4*i), ctrl(12'd2, 5'd0), 1'b0, 5'd0, 32'd0);
      lit("t6_pre_ovf", {31'd0, ovf}, 32'd1);
      do_reset();
      @(negedge clk); #1;
      chk("t6_valid", {31'd0, bus.evt_valid}, 32'd0);
      chk("t6_ovf", {31'd0, ovf}, 32'd0);
      chk("t6_term", {31'd0, term}, 32'd0);
      chk("t6_r3", r3, 32'd0);

      // Test 4: EXIT, then PUTC ignored while draining
      retire(32'h400, 32'h0000_0193, 1'b1, 5'd3, 32'd0);
      retire(32'h404, ctrl(12'd1, 5'd0), 1'b0, 5'd0, 32'd0);
      retire(32'h408, ctrl(12'd4, 5'd0), 1'b0, 5'd0, 32'd0);
      idle();
      @(negedge clk); #1;
      chk("t4_head_type", {30'd0, bus.evt_type}, 32'd1);
      chk("t4_head_pc", bus.evt_pc, 32'h404);
      chk("t4_not_term", {31'd0, term}, 32'd0);
      bus.evt_ready = 1'b1;
      idle();
      bus.evt_ready = 1'b0;
      lit("t4_putc_dropped", {31'd0, bus.evt_valid}, 32'd0);
      chk("t4_term_wait", {31'd0, term}, 32'd0);
      idle();
      lit("t4_term", {31'd0, term}, 32'd1);
      retire(32'h40C, ctrl(12'd2, 5'd0), 1'b0, 5'd0, 32'd0);
      lit("t4_done_no_evt", {31'd0, bus.evt_valid}, 32'd0);
      chk("t4_done_no_ovf", {31'd0, ovf}, 32'd0);
      idle();
      idle();

      chk_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
